// File: rtl/poly_pkg.sv
// poly_pkg: shared FSM encoding and default sizing for the Horner evaluator
package poly_pkg;
  localparam int WIDTH_D = 16;
  localparam int DEGREE_MAX_D = 7;
  localparam int ADDR_W_D = 3;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] ACC = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
endpackage

// File: rtl/horner_mac.sv
// horner_mac: one Horner step, acc*x+coef truncated to WIDTH, or coef alone on the first step
module horner_mac import poly_pkg::*; #(
  parameter int WIDTH = WIDTH_D
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] coef,
  input  logic             first,
  output logic [WIDTH-1:0] y
);
  assign y = first ? coef : acc * x + coef;
endmodule

// File: rtl/horner_sequencer.sv
// horner_sequencer: evaluates a polynomial by Horner's rule, fetching one coefficient per step
module horner_sequencer import poly_pkg::*; #(
  parameter int WIDTH = WIDTH_D,
  parameter int DEGREE_MAX = DEGREE_MAX_D,
  parameter int ADDR_W = ADDR_W_D
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] degree,
  input  logic [WIDTH-1:0]  x,
  output logic              busy,
  output logic              coef_rd,
  output logic [ADDR_W-1:0] coef_addr,
  input  logic [WIDTH-1:0]  coef_data,
  output logic [WIDTH-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready
);
  localparam logic [ADDR_W-1:0] DMAX = ADDR_W'(DEGREE_MAX);
  logic [1:0] state, next;
  logic [ADDR_W-1:0] k;
  logic [WIDTH-1:0] acc, xr, res, mac;
  logic first;
  horner_mac #(.WIDTH(WIDTH)) u_mac (.acc(acc), .x(xr), .coef(coef_data), .first(first), .y(mac));
  assign busy = state != IDLE;
  assign coef_rd = state == FETCH;
  assign coef_addr = k;
  assign result_valid = state == DONE;
  assign result = res;
  // next-state selection; start only matters in IDLE
  always_comb begin
    next = state == IDLE  ? (start ? FETCH : IDLE) :
           state == FETCH ? ACC :
           state == ACC   ? (k == '0 ? DONE : FETCH) :
                            (result_ready ? IDLE : DONE);
  end
  // state, operand latch, coefficient index and accumulator/result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      k <= '0;
      acc <= '0;
      xr <= '0;
      res <= '0;
      first <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE && start) begin
        xr <= x;
        k <= degree > DMAX ? DMAX : degree;
        first <= 1'b1;
      end
      if (state == ACC) begin
        acc <= mac;
        first <= 1'b0;
        if (k == '0) res <= mac;
        else k <= k - 1'b1;
      end
    end
  end
endmodule

// File: doc/horner_sequencer.md
HORNER_SEQUENCER -- requirements
Module: horner_sequencer

Interface
REQ-001 Parameter WIDTH, default 16: coefficient, x and result width in bits.
REQ-002 Parameter DEGREE_MAX, default 7: highest supported polynomial degree.
REQ-003 Parameter ADDR_W, default 3: coefficient address width, equal to ceil(log2(DEGREE_MAX+1)).
REQ-004 clock  input  1  rising-edge clock; the block has one clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request to evaluate; sampled only in IDLE.
REQ-007 degree  input  ADDR_W  polynomial degree n; sampled with start.
REQ-008 x  input  WIDTH  evaluation point (two's complement); sampled with start.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 coef_rd  output  1  coefficient read strobe.
REQ-011 coef_addr  output  ADDR_W  coefficient index k being read.
REQ-012 coef_data  input  WIDTH  coefficient a_k; valid the cycle after coef_rd.
REQ-013 result  output  WIDTH  evaluated polynomial value.
REQ-014 result_valid  output  1  result available; held until accepted.
REQ-015 result_ready  input  1  consumer accepts result when high with result_valid.

Function
REQ-016 The FSM SHALL have the states IDLE, FETCH, ACC and DONE.
REQ-017 IDLE with start=1 SHALL latch x, set k=min(degree, DEGREE_MAX), set first=1 and go to FETCH; start=0 keeps the FSM in IDLE.
REQ-018 FETCH SHALL drive coef_rd=1 and coef_addr=k, then go to ACC; coef_rd SHALL be 0 in all other states.
REQ-019 ACC SHALL load acc with coef_data when first=1, or with acc*x+coef_data when first=0, and SHALL clear first.
REQ-020 Arithmetic SHALL be two's complement with the product and the sum each truncated to WIDTH bits (modulo 2^WIDTH); no saturation and no overflow flag.
REQ-021 ACC with k=0 SHALL go to DONE; ACC with k>0 SHALL decrement k and go to FETCH.
REQ-022 Latency: result_valid SHALL rise 2*(n+1) clock edges after the edge that accepts start (n=0 gives 2 edges).
REQ-023 DONE SHALL drive result_valid=1 and result=acc, both stable, until result_ready=1; DONE with result_ready=1 SHALL return to IDLE.
REQ-024 start SHALL be ignored in FETCH, ACC and DONE, including the DONE cycle in which result_ready is accepted.
REQ-025 A degree value above DEGREE_MAX SHALL be clamped to DEGREE_MAX.
REQ-026 result SHALL hold the last completed value while in IDLE.

Reset
REQ-027 reset=1 at a rising edge SHALL put the FSM in IDLE from any state and abort any evaluation in progress.
REQ-028 After reset: busy=0, coef_rd=0, coef_addr=0, result_valid=0, result=0, acc=0, k=0, first=0.
REQ-029 Reset SHALL take priority over start and over result_ready in the same cycle.

Structure
REQ-030 The state encoding and the default WIDTH, DEGREE_MAX and ADDR_W constants SHALL be placed in the shared package poly_pkg.
REQ-031 The multiply-add with truncation SHALL be a combinational sub-module horner_mac(acc, x, coef, first) returning WIDTH bits.
REQ-032 The FSM, k counter and result register SHALL live in horner_sequencer.

Verification (WIDTH=16; memory model returns coef_data one cycle after coef_rd)
REQ-033 Coefficients [a0..a3]=[1,2,3,4], x=2, degree=3 -> result=49 (0x0031), result_valid 8 edges after start, coef_addr sequence 3,2,1,0.
REQ-034 degree=0, a0=0x1234, x=5 -> result=0x1234 after 2 edges, with a single coef_rd at address 0.
REQ-035 Coefficients [0,0,1], x=256, degree=2 -> result=0x0000 (wrap); x=0xFFFF, coefficients [1,2,3], degree=2 -> result=2.
REQ-036 result_ready held low 5 cycles after result_valid, and start pulsed while busy -> result and result_valid stable, no new evaluation starts, and return to IDLE on the first ready cycle.
REQ-037 reset asserted in the middle of a degree-5 run -> next cycle busy=0, result_valid=0, result=0; a new start then completes correctly.
REQ-038 degree=7 with DEGREE_MAX=5, ADDR_W=3 -> first coef_addr=5 and 12-edge latency.
